// File: rtl/di_ex_stage_pkg.sv
// Shared definitions for the decode/issue (DI/EX) stage.
//  - datapath width and default scoreboard depth
//  - opcode constants and ALU control encodings
//  - small decode helpers: ALU control, writer/reader classification
package di_ex_stage_pkg;

  localparam int WIDTH         = 8;
  localparam int DEF_HAZ_DEPTH = 3;

  localparam logic [WIDTH-1:0] OP_NOP   = 8'h00;
  localparam logic [WIDTH-1:0] OP_ADD   = 8'h01;
  localparam logic [WIDTH-1:0] OP_MUL   = 8'h02;
  localparam logic [WIDTH-1:0] OP_SOU   = 8'h03;
  localparam logic [WIDTH-1:0] OP_DIV   = 8'h04;
  localparam logic [WIDTH-1:0] OP_COP   = 8'h05;
  localparam logic [WIDTH-1:0] OP_AFC   = 8'h06;
  localparam logic [WIDTH-1:0] OP_LOAD  = 8'h07;
  localparam logic [WIDTH-1:0] OP_STORE = 8'h08;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_MUL  = 3'b010,
    ALU_SOU  = 3'b011,
    ALU_DIV  = 3'b100
  } alu_ctrl_e;

  function automatic alu_ctrl_e alu_ctrl(input logic [WIDTH-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_MUL:  return ALU_MUL;
      OP_SOU:  return ALU_SOU;
      OP_DIV:  return ALU_DIV;
      default: return ALU_PASS;
    endcase
  endfunction

  // Instructions that write their destination register (ADD..LOAD).
  function automatic logic is_writer(input logic [WIDTH-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LOAD);
  endfunction

  // In_B is a register source for arithmetic, COP and STORE; an immediate otherwise.
  function automatic logic reads_b(input logic [WIDTH-1:0] op);
    return ((op >= OP_ADD) && (op <= OP_COP)) || (op == OP_STORE);
  endfunction

  // In_C is a register source only for the four arithmetic ops.
  function automatic logic reads_c(input logic [WIDTH-1:0] op);
    return (op >= OP_ADD) && (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/di_ex_stage_if.sv
// Bundle between the LI/DI latch + register file (master side) and the DI/EX stage
// (slave side).
//  In_Valid/In_OP/In_A/In_B/In_C : instruction held in LI/DI
//  QA/QB                         : async register-file data for In_B / In_C
//  Hold                          : downstream freeze
//  Stall                         : LI/DI must keep its contents
//  Out_*                         : DI/EX pipeline register contents
interface di_ex_stage_if;
  import di_ex_stage_pkg::*;

  logic             In_Valid;
  logic [WIDTH-1:0] In_OP;
  logic [WIDTH-1:0] In_A;
  logic [WIDTH-1:0] In_B;
  logic [WIDTH-1:0] In_C;
  logic [WIDTH-1:0] QA;
  logic [WIDTH-1:0] QB;
  logic             Hold;
  logic             Stall;
  logic             Out_Valid;
  logic [WIDTH-1:0] Out_OP;
  logic [WIDTH-1:0] Out_A;
  logic [WIDTH-1:0] Out_B;
  logic [WIDTH-1:0] Out_C;
  logic [2:0]       Out_Ctrl_Alu;

  modport master (
    output In_Valid, In_OP, In_A, In_B, In_C, QA, QB, Hold,
    input  Stall, Out_Valid, Out_OP, Out_A, Out_B, Out_C, Out_Ctrl_Alu
  );

  modport slave (
    input  In_Valid, In_OP, In_A, In_B, In_C, QA, QB, Hold,
    output Stall, Out_Valid, Out_OP, Out_A, Out_B, Out_C, Out_Ctrl_Alu
  );
endinterface

// File: rtl/di_ex_stage_hazard_scoreboard.sv
// RAW hazard scoreboard: a HAZ_DEPTH-deep shift register of {valid, dest} for the
// writers in flight (slot 0 = entering EX, last slot = WB), plus comparators
// against the sources of the instruction waiting in LI/DI.
//  i_clk, i_rst      : clock, synchronous active-high reset
//  i_hold            : freeze the scoreboard
//  i_valid           : LI/DI holds a real instruction
//  i_src_b/i_rd_b    : source register on In_B and whether it is read
//  i_src_c/i_rd_c    : source register on In_C and whether it is read
//  i_push, i_dest    : a writer is issuing this cycle, and its destination
//  o_hazard          : combinational RAW hazard
module hazard_scoreboard #(
  parameter int WIDTH     = 8,
  parameter int HAZ_DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_rd_b,
  input  logic [WIDTH-1:0] i_src_c,
  input  logic             i_rd_c,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dest,
  output logic             o_hazard
);

  logic [HAZ_DEPTH-1:0] r_v;
  logic [WIDTH-1:0]     r_dest [HAZ_DEPTH];
  logic                 w_hit;

  // Only entries already in flight are compared, so an instruction whose
  // destination equals one of its own sources never blocks itself. The WB slot
  // is included because the register file is not write-then-read in one cycle.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (r_v[i] && ((i_rd_b && (r_dest[i] == i_src_b)) ||
                     (i_rd_c && (r_dest[i] == i_src_c)))) begin
        w_hit = 1'b1;
      end
    end
  end

  assign o_hazard = i_valid & w_hit;

  // ---- scoreboard shift (one slot per unfrozen cycle) ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v <= '0;
    end else if (!i_hold) begin
      r_v[0] <= i_push;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  // Destinations are meaningless while their valid bit is clear, so no reset.
  always_ff @(posedge i_clk) begin
    if (!i_hold) begin
      r_dest[0] <= i_dest;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        r_dest[i] <= r_dest[i-1];
      end
    end
  end

endmodule

// File: rtl/di_ex_stage.sv
// Decode/issue stage in front of the ALU. Decodes the LI/DI instruction, selects
// register-file or immediate operands, translates the opcode into ALU control and
// registers the result into DI/EX. RAW hazards against in-flight writers stall
// LI/DI and insert NOP bubbles.
//  CLK, RST : clock, synchronous active-high reset (overrides Hold)
//  bus      : slave side of di_ex_stage_if (LI/DI inputs, register-file data,
//             Hold in; Stall and DI/EX contents out)
module di_ex_stage
  import di_ex_stage_pkg::*;
#(
  parameter int HAZ_DEPTH = DEF_HAZ_DEPTH
) (
  input logic          CLK,
  input logic          RST,
  di_ex_stage_if.slave bus
);

  logic             w_hazard;
  logic             w_issue;
  logic             w_rd_b;
  logic             w_rd_c;
  logic             w_wr;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_c;
  alu_ctrl_e        w_ctrl;

  logic             r_valid;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_ctrl;

  assign w_rd_b  = reads_b(bus.In_OP);
  assign w_rd_c  = reads_c(bus.In_OP);
  assign w_wr    = is_writer(bus.In_OP);
  assign w_ctrl  = alu_ctrl(bus.In_OP);
  assign w_issue = bus.In_Valid & ~w_hazard;

  hazard_scoreboard #(
    .WIDTH     (WIDTH),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_scoreboard (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_hold   (bus.Hold),
    .i_valid  (bus.In_Valid),
    .i_src_b  (bus.In_B),
    .i_rd_b   (w_rd_b),
    .i_src_c  (bus.In_C),
    .i_rd_c   (w_rd_c),
    .i_push   (w_issue & w_wr),
    .i_dest   (bus.In_A),
    .o_hazard (w_hazard)
  );

  // While reset is asserted the scoreboard contents are stale, so only Hold stalls.
  assign bus.Stall = bus.Hold | (w_hazard & ~RST);

  // Operand selection: AFC/LOAD carry an immediate/address in In_B.
  always_comb begin
    w_b = '0;
    w_c = '0;
    case (bus.In_OP)
      OP_ADD, OP_MUL, OP_SOU, OP_DIV: begin
        w_b = bus.QA;
        w_c = bus.QB;
      end
      OP_COP, OP_STORE: w_b = bus.QA;
      OP_AFC, OP_LOAD:  w_b = bus.In_B;
      default: ;
    endcase
  end

  // ---- LI/DI -> DI/EX register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_ctrl  <= '0;
    end else if (!bus.Hold) begin
      if (w_issue) begin
        r_valid <= 1'b1;
        r_op    <= bus.In_OP;
        r_a     <= bus.In_A;
        r_b     <= w_b;
        r_c     <= w_c;
        r_ctrl  <= w_ctrl;
      end else begin
        r_valid <= 1'b0;
        r_op    <= OP_NOP;
        r_a     <= '0;
        r_b     <= '0;
        r_c     <= '0;
        r_ctrl  <= ALU_PASS;
      end
    end
  end

  assign bus.Out_Valid    = r_valid;
  assign bus.Out_OP       = r_op;
  assign bus.Out_A        = r_a;
  assign bus.Out_B        = r_b;
  assign bus.Out_C        = r_c;
  assign bus.Out_Ctrl_Alu = r_ctrl;

endmodule

// File: tb/tb_di_ex_stage.sv
// Directed, table-driven bench for di_ex_stage. Register file model: Rn holds 0x10+n.
module tb_di_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  di_ex_stage_if bus ();

  di_ex_stage dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.QA = bus.In_B + 8'h10;
  assign bus.QB = bus.In_C + 8'h10;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] op, a, b, c;
    logic       hold;
    logic       e_stall;
    logic       e_vld;
    logic [7:0] e_op, e_a, e_b, e_c;
    logic [2:0] e_ctrl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input logic r, input logic vl, input logic [7:0] op,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic h, input logic es, input logic ev,
                             input logic [7:0] eop, input logic [7:0] ea,
                             input logic [7:0] eb, input logic [7:0] ec,
                             input logic [2:0] ectl);
    vec_t v;
    v.rst = r; v.vld = vl; v.op = op; v.a = a; v.b = b; v.c = c; v.hold = h;
    v.e_stall = es; v.e_vld = ev; v.e_op = eop; v.e_a = ea; v.e_b = eb; v.e_c = ec;
    v.e_ctrl = ectl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst          = v.rst;
    bus.In_Valid = v.vld;
    bus.In_OP    = v.op;
    bus.In_A     = v.a;
    bus.In_B     = v.b;
    bus.In_C     = v.c;
    bus.Hold     = v.hold;
    #1;
    chk({tag, " Stall"}, {7'd0, bus.Stall}, {7'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({tag, " Out_Valid"}, {7'd0, bus.Out_Valid}, {7'd0, v.e_vld});
    chk({tag, " Out_OP"}, bus.Out_OP, v.e_op);
    chk({tag, " Out_B"}, bus.Out_B, v.e_b);
    chk({tag, " Out_C"}, bus.Out_C, v.e_c);
    chk({tag, " Out_Ctrl_Alu"}, {5'd0, bus.Out_Ctrl_Alu}, {5'd0, v.e_ctrl});
    if (v.e_vld || v.rst) chk({tag, " Out_A"}, bus.Out_A, v.e_a);
  endtask

  initial begin
    bus.In_Valid = 1'b0;
    bus.In_OP    = '0;
    bus.In_A     = '0;
    bus.In_B     = '0;
    bus.In_C     = '0;
    bus.Hold     = 1'b0;

    // reset with a valid instruction present
    tbl.push_back(V(1,1,8'h06,8'h01,8'h05,8'h00,0, 0,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    tbl.push_back(V(1,1,8'h06,8'h01,8'h05,8'h00,0, 0,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    // AFC R1,#5 ; AFC R2,#7 back to back
    tbl.push_back(V(0,1,8'h06,8'h01,8'h05,8'h00,0, 0,1,8'h06,8'h01,8'h05,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h06,8'h02,8'h07,8'h00,0, 0,1,8'h06,8'h02,8'h07,8'h00,3'd0));
    // idle cycles drain the scoreboard
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0,0,8'h00,8'h00,8'h00,8'h00,0, 0,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    // AFC R1,#5 ; ADD R3,R1,R2 -> three bubbles then ADD
    tbl.push_back(V(0,1,8'h06,8'h01,8'h05,8'h00,0, 0,1,8'h06,8'h01,8'h05,8'h00,3'd0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0,1,8'h01,8'h03,8'h01,8'h02,0, 1,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h01,8'h03,8'h01,8'h02,0, 0,1,8'h01,8'h03,8'h11,8'h12,3'd1));
    // AFC R1 ; AFC R4 ; ADD R3,R1,R2 -> two bubbles
    tbl.push_back(V(0,1,8'h06,8'h01,8'h09,8'h00,0, 0,1,8'h06,8'h01,8'h09,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h06,8'h04,8'h03,8'h00,0, 0,1,8'h06,8'h04,8'h03,8'h00,3'd0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(V(0,1,8'h01,8'h03,8'h01,8'h02,0, 1,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h01,8'h03,8'h01,8'h02,0, 0,1,8'h01,8'h03,8'h11,8'h12,3'd1));
    // ADD R5,R5,R6 : own destination is not a hazard
    tbl.push_back(V(0,1,8'h01,8'h05,8'h05,8'h06,0, 0,1,8'h01,8'h05,8'h15,8'h16,3'd1));
    // SOU R7,R8,R9 then MUL R6,R7,R1 under Hold for two cycles
    tbl.push_back(V(0,1,8'h03,8'h07,8'h08,8'h09,0, 0,1,8'h03,8'h07,8'h18,8'h19,3'd3));
    for (int i = 0; i < 2; i++)
      tbl.push_back(V(0,1,8'h02,8'h06,8'h07,8'h01,1, 1,1,8'h03,8'h07,8'h18,8'h19,3'd3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0,1,8'h02,8'h06,8'h07,8'h01,0, 1,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h02,8'h06,8'h07,8'h01,0, 0,1,8'h02,8'h06,8'h17,8'h11,3'd2));
    // COP R8,R2 ; STORE [40],R3 with In_C=R8 (not a read) ; LOAD R9,[06] (immediate)
    tbl.push_back(V(0,1,8'h05,8'h08,8'h02,8'h00,0, 0,1,8'h05,8'h08,8'h12,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h08,8'h40,8'h03,8'h08,0, 0,1,8'h08,8'h40,8'h13,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h07,8'h09,8'h06,8'h00,0, 0,1,8'h07,8'h09,8'h06,8'h00,3'd0));
    // DIV R10,R9,R8 : R9 must travel through all three slots (WB still blocks)
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0,1,8'h04,8'h0A,8'h09,8'h08,0, 1,0,8'h00,8'h00,8'h00,8'h00,3'd0));
    tbl.push_back(V(0,1,8'h04,8'h0A,8'h09,8'h08,0, 0,1,8'h04,8'h0A,8'h19,8'h18,3'd4));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a hazard: AFC R1 ; ADD R3,R1,R2 stalls ; RST clears.
    apply(V(0,1,8'h06,8'h01,8'h01,8'h00,0, 0,1,8'h06,8'h01,8'h01,8'h00,3'd0), "mid_afc");
    apply(V(0,1,8'h01,8'h03,8'h01,8'h02,0, 1,0,8'h00,8'h00,8'h00,8'h00,3'd0), "mid_bubble");
    apply(V(1,1,8'h01,8'h03,8'h01,8'h02,0, 0,0,8'h00,8'h00,8'h00,8'h00,3'd0), "mid_rst");
    apply(V(1,1,8'h01,8'h03,8'h01,8'h02,1, 1,0,8'h00,8'h00,8'h00,8'h00,3'd0), "mid_rst_hold");
    apply(V(0,1,8'h01,8'h03,8'h01,8'h02,0, 0,1,8'h01,8'h03,8'h11,8'h12,3'd1), "mid_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
